prog_counter: RTL and testbench
===============================

PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits (legal range 2..32).
REQ-002 SHALL have parameter PRESCALE, default 1, number of qualifying enabled cycles per count step (legal range 1..256).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  count enable.
REQ-006 SHALL have port up_dn  input  1  direction: 1 = up, 0 = down.
REQ-007 SHALL have port sat_mode  input  1  boundary behaviour: 1 = saturate, 0 = wrap.
REQ-008 SHALL have port max_val  input  WIDTH  runtime terminal value; count range is 0..max_val.
REQ-009 SHALL have port load  input  1  synchronous load strobe.
REQ-010 SHALL have port load_val  input  WIDTH  value to load.
REQ-011 SHALL have port clr_ovf  input  1  clears the sticky overflow flag.
REQ-012 SHALL have port count  output  WIDTH  registered counter value.
REQ-013 SHALL have port wrap  output  1  registered one-cycle pulse on a boundary event.
REQ-014 SHALL have port ovf  output  1  registered sticky flag, set by any boundary event.

Function
REQ-015 SHALL apply per-edge priority: reset > load > en; en is ignored on a load cycle.
REQ-016 SHALL, on load, set count = min(load_val, max_val), clear the prescaler, and leave wrap at 0 and ovf unchanged.
REQ-017 SHALL implement the prescaler as a 0..PRESCALE-1 counter advanced on each en cycle; a step occurs on the en cycle where the prescaler equals PRESCALE-1, and the prescaler then returns to 0.
REQ-018 SHALL, with PRESCALE = 1, step on every en cycle (prescaler logic reduces to a constant).
REQ-019 SHALL hold count and the prescaler when en = 0; wrap = 0 on such cycles.
REQ-020 SHALL, on an up step with count < max_val, set count = count + 1.
REQ-021 SHALL, on an up step with count >= max_val, set count = 0 (wrap mode) or count = max_val (saturate mode); this is a boundary event.
REQ-022 SHALL, on a down step with count > 0, set count = count - 1, including when count > max_val after max_val was lowered.
REQ-023 SHALL, on a down step with count = 0, set count = max_val (wrap mode) or hold 0 (saturate mode); this is a boundary event.
REQ-024 SHALL treat max_val = 0 as: count stays 0 and every step is a boundary event.
REQ-025 SHALL assert wrap for exactly the cycle after each boundary event (registered); back-to-back events give wrap high on consecutive cycles.
REQ-026 SHALL set ovf on the edge that registers a boundary event and clear it on clr_ovf; when both occur on the same edge, set wins.
REQ-027 SHALL sample up_dn, sat_mode and max_val on the step edge only; changes between steps have no other effect.
REQ-028 SHALL perform all arithmetic modulo 2^WIDTH without unintended carry out; no combinational path from inputs to outputs.

Reset
REQ-029 SHALL, when reset = 1 at a rising edge, set count = 0, prescaler = 0, wrap = 0 and ovf = 0, overriding load, en and clr_ovf.
REQ-030 SHALL abandon any partial prescale period on reset mid-operation; counting resumes from a full period after reset deasserts.

Verification
REQ-031 SHALL pass this case: WIDTH=4, PRESCALE=1, max_val=15, up, wrap, en=1 for 17 cycles after reset -> count 1..15, 0, 1; wrap high exactly one cycle after count goes 15->0; ovf=1 thereafter.
REQ-032 SHALL pass this case: max_val=9, down, saturate, load_val=2 then en for 5 cycles -> count 2,1,0,0,0; wrap pulses on each of the final two steps; clr_ovf with no event -> ovf=0.
REQ-033 SHALL pass this case: PRESCALE=3, up, en=1 for 9 cycles from 0 -> count increments only on cycles 3, 6 and 9 (values 1, 2, 3); en=0 mid-period holds the prescaler.
REQ-034 SHALL pass this case: load_val=12 with max_val=9 -> count=9; load and en together -> load wins, no step.
REQ-035 SHALL pass this case: clr_ovf on the same edge as a boundary event -> ovf=1; reset asserted mid-prescale with load=1 -> count=0, ovf=0, wrap=0.
REQ-036 SHALL pass this case: max_val lowered from 15 to 5 while count=10; up/wrap step -> count=0 with wrap pulse; down step instead -> count=9.

Source files
------------

// File: rtl/prog_counter.sv
// prog_counter: programmable up/down counter with a runtime terminal value,
// wrap/saturate boundary behaviour, an optional enable prescaler, a registered
// boundary pulse (wrap) and a sticky boundary flag (ovf).
module prog_counter #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             sat_mode,
   input  logic [WIDTH-1:0] max_val,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] count,
   output logic             wrap,
   output logic             ovf
);

   // Prescaler width; one bit minimum keeps declarations legal when unused.
   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   // High on the enabled cycle that completes a prescale period.
   logic step;

   logic [WIDTH-1:0] count_reg;
   logic [WIDTH-1:0] count_next;
   logic             wrap_reg;
   logic             ovf_reg;
   logic             boundary;
   logic [WIDTH-1:0] load_clamped;

   generate
      if (PRESCALE == 1) begin : g_no_presc
         // Every enabled cycle is a step; no prescaler state exists.
         assign step = en;
      end else begin : g_presc
         localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

         logic [PW-1:0] presc_reg;
         logic [PW-1:0] presc_next;

         // Advance through 0..PRESCALE-1 on enabled cycles, returning to 0 after the last.
         always_comb begin
            presc_next = presc_reg;
            if (en) begin
               if (presc_reg == PRESC_LAST) begin
                  presc_next = '0;
               end else begin
                  presc_next = presc_reg + PW'(1);
               end
            end
         end

         // Reset and load both abandon any partial prescale period.
         always_ff @(posedge clk) begin
            if (reset) begin
               presc_reg <= '0;
            end else if (load) begin
               presc_reg <= '0;
            end else begin
               presc_reg <= presc_next;
            end
         end

         assign step = en && (presc_reg == PRESC_LAST);
      end
   endgenerate

   // A load never exceeds the current terminal value.
   assign load_clamped = (load_val > max_val) ? max_val : load_val;

   // Next count and boundary detection; direction, mode and terminal value matter only on a step.
   always_comb begin
      count_next = count_reg;
      boundary   = 1'b0;
      if (step) begin
         if (up_dn) begin
            // ">=" also covers a count left above a lowered terminal value.
            if (count_reg >= max_val) begin
               boundary   = 1'b1;
               count_next = sat_mode ? max_val : ZERO;
            end else begin
               count_next = count_reg + ONE;
            end
         end else begin
            // Plain decrement even when the count sits above max_val.
            if (count_reg == ZERO) begin
               boundary   = 1'b1;
               count_next = sat_mode ? ZERO : max_val;
            end else begin
               count_next = count_reg - ONE;
            end
         end
      end
   end

   // Count and boundary pulse: reset over load over counting.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= ZERO;
         wrap_reg  <= 1'b0;
      end else if (load) begin
         count_reg <= load_clamped;
         wrap_reg  <= 1'b0;
      end else begin
         count_reg <= count_next;
         wrap_reg  <= boundary;
      end
   end

   // Sticky flag: a boundary event wins over a simultaneous clear; a load cycle leaves it alone.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_reg <= 1'b0;
      end else if (load) begin
         ovf_reg <= ovf_reg;
      end else if (boundary) begin
         ovf_reg <= 1'b1;
      end else if (clr_ovf) begin
         ovf_reg <= 1'b0;
      end
   end

   assign count = count_reg;
   assign wrap  = wrap_reg;
   assign ovf   = ovf_reg;

endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: two counters (PRESCALE 1 and 3) share one stimulus stream
// and are checked every cycle against a behavioural model, with directed
// scenarios pinning literal values along the way, then a random phase.
module tb_prog_counter;

   logic       clk = 1'b0;
   logic       reset, en, up_dn, sat_mode, load, clr_ovf;
   logic [3:0] max_val, load_val;
   logic [3:0] count1, count3;
   logic       wrap1, wrap3, ovf1, ovf3;

   int total = 0;
   int bad   = 0;

   // Model state per instance: index 0 -> PRESCALE 1, index 1 -> PRESCALE 3.
   int m_cnt [2];
   int m_pre [2];
   int m_wrap[2];
   int m_ovf [2];
   int m_valid = 0;
   int ps    [2] = '{1, 3};

   always #5 clk = ~clk;

   prog_counter #(.WIDTH(4), .PRESCALE(1)) dut1 (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
      .max_val(max_val), .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
      .count(count1), .wrap(wrap1), .ovf(ovf1)
   );

   prog_counter #(.WIDTH(4), .PRESCALE(3)) dut3 (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
      .max_val(max_val), .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
      .count(count3), .wrap(wrap3), .ovf(ovf3)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: counts qualifying enabled cycles, steps after PRESCALE of them.
   always @(posedge clk) begin
      int c, p, w, o, mv, lv, bnd;
      for (int k = 0; k < 2; k++) begin
         c  = m_cnt[k];
         p  = m_pre[k];
         w  = 0;
         o  = m_ovf[k];
         mv = int'(max_val);
         lv = int'(load_val);
         if (reset) begin
            c = 0; p = 0; o = 0;
         end else if (load) begin
            c = (lv < mv) ? lv : mv;
            p = 0;
         end else begin
            bnd = 0;
            if (en) begin
               p = p + 1;
               if (p == ps[k]) begin
                  p = 0;
                  if (up_dn) begin
                     if (c >= mv) begin bnd = 1; c = sat_mode ? mv : 0; end
                     else c = c + 1;
                  end else begin
                     if (c == 0) begin bnd = 1; c = sat_mode ? 0 : mv; end
                     else c = c - 1;
                  end
               end
            end
            w = bnd;
            if (bnd != 0) o = 1;
            else if (clr_ovf) o = 0;
         end
         m_cnt[k]  <= c;
         m_pre[k]  <= p;
         m_wrap[k] <= w;
         m_ovf[k]  <= o;
      end
      if (reset) m_valid <= 1;
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (m_valid != 0) begin
         chk("model_count_p1", int'(count1), m_cnt[0]);
         chk("model_wrap_p1",  int'(wrap1),  m_wrap[0]);
         chk("model_ovf_p1",   int'(ovf1),   m_ovf[0]);
         chk("model_count_p3", int'(count3), m_cnt[1]);
         chk("model_wrap_p3",  int'(wrap3),  m_wrap[1]);
         chk("model_ovf_p3",   int'(ovf3),   m_ovf[1]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 1'b0; load = 1'b0; en = 1'b0; clr_ovf = 1'b0;
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; up_dn = 1'b1; sat_mode = 1'b0; load = 1'b0;
      clr_ovf = 1'b0; max_val = 4'd15; load_val = 4'd0;
      tick(); tick();
      chk("reset_count", int'(count1), 0);
      chk("reset_wrap",  int'(wrap1), 0);
      chk("reset_ovf",   int'(ovf1), 0);
      chk("reset_count_p3", int'(count3), 0);

      // Full wrap at max_val = 15.
      idle(); en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0; max_val = 4'd15;
      for (int i = 1; i <= 17; i++) begin
         tick();
         chk($sformatf("up_wrap_count_%0d", i), int'(count1), i % 16);
         chk($sformatf("up_wrap_wrap_%0d", i), int'(wrap1), (i == 16) ? 1 : 0);
         chk($sformatf("up_wrap_ovf_%0d", i), int'(ovf1), (i >= 16) ? 1 : 0);
      end

      // Down, saturate, from a load of 2.
      idle(); max_val = 4'd9; up_dn = 1'b0; sat_mode = 1'b1; load = 1'b1; load_val = 4'd2;
      tick();
      chk("sat_load", int'(count1), 2);
      load = 1'b0; en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         int exp_c [4] = '{1, 0, 0, 0};
         tick();
         chk($sformatf("sat_down_count_%0d", i), int'(count1), exp_c[i]);
         chk($sformatf("sat_down_wrap_%0d", i), int'(wrap1), (i >= 2) ? 1 : 0);
      end
      en = 1'b0; clr_ovf = 1'b1;
      tick();
      chk("clr_ovf_no_event", int'(ovf1), 0);
      chk("clr_ovf_wrap", int'(wrap1), 0);

      // Prescale 3 from a fresh reset; en gaps hold the prescaler.
      idle(); reset = 1'b1;
      tick();
      idle(); en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0; max_val = 4'd15;
      for (int i = 1; i <= 9; i++) begin
         tick();
         chk($sformatf("presc_count_%0d", i), int'(count3), i / 3);
      end
      tick();
      chk("presc_partial", int'(count3), 3);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("presc_hold", int'(count3), 3);
      end
      en = 1'b1;
      tick();
      chk("presc_resume_a", int'(count3), 3);
      tick();
      chk("presc_resume_b", int'(count3), 4);

      // Load clamping and load-over-enable priority.
      idle(); max_val = 4'd9; load = 1'b1; load_val = 4'd12;
      tick();
      chk("load_clamp", int'(count1), 9);
      load_val = 4'd3; en = 1'b1; up_dn = 1'b1;
      tick();
      chk("load_wins", int'(count1), 3);
      chk("load_wins_wrap", int'(wrap1), 0);
      load = 1'b0;
      tick();
      chk("after_load_step", int'(count1), 4);

      // Boundary event and clear on the same edge.
      idle(); load = 1'b1; load_val = 4'd9;
      tick();
      idle(); en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0; clr_ovf = 1'b1;
      tick();
      chk("set_beats_clr_count", int'(count1), 0);
      chk("set_beats_clr_wrap", int'(wrap1), 1);
      chk("set_beats_clr_ovf", int'(ovf1), 1);

      // Reset in the middle of a prescale period, with load and en asserted.
      idle(); en = 1'b1; max_val = 4'd15;
      tick();
      reset = 1'b1; load = 1'b1; load_val = 4'd5;
      tick();
      chk("rst_mid_count", int'(count3), 0);
      chk("rst_mid_ovf", int'(ovf1), 0);
      chk("rst_mid_wrap", int'(wrap1), 0);
      idle(); en = 1'b1; up_dn = 1'b1;
      tick(); tick();
      chk("rst_full_period_a", int'(count3), 0);
      tick();
      chk("rst_full_period_b", int'(count3), 1);

      // Terminal value lowered below the count.
      idle(); max_val = 4'd15; load = 1'b1; load_val = 4'd10;
      tick();
      idle(); max_val = 4'd5; up_dn = 1'b1; sat_mode = 1'b0; en = 1'b1;
      tick();
      chk("lowered_up_count", int'(count1), 0);
      chk("lowered_up_wrap", int'(wrap1), 1);
      idle(); max_val = 4'd15; load = 1'b1; load_val = 4'd10;
      tick();
      idle(); max_val = 4'd5; up_dn = 1'b0; en = 1'b1;
      tick();
      chk("lowered_down_count", int'(count1), 9);
      chk("lowered_down_wrap", int'(wrap1), 0);

      // Saturate up at the terminal value, and max_val = 0.
      idle(); load = 1'b1; load_val = 4'd5;
      tick();
      idle(); up_dn = 1'b1; sat_mode = 1'b1; en = 1'b1;
      tick();
      chk("sat_up_count", int'(count1), 5);
      chk("sat_up_wrap", int'(wrap1), 1);
      idle(); max_val = 4'd0; load = 1'b1; load_val = 4'd7;
      tick();
      chk("zero_max_load", int'(count1), 0);
      idle(); en = 1'b1; sat_mode = 1'b0; up_dn = 1'b0;
      tick();
      chk("zero_max_count", int'(count1), 0);
      chk("zero_max_wrap", int'(wrap1), 1);

      // Random phase; the per-cycle checker does the work.
      for (int i = 0; i < 2000; i++) begin
         reset    = ($urandom_range(0, 63) == 0);
         load     = ($urandom_range(0, 7) == 0);
         load_val = 4'($urandom);
         en       = ($urandom_range(0, 3) != 0);
         up_dn    = 1'($urandom_range(0, 1));
         sat_mode = 1'($urandom_range(0, 1));
         clr_ovf  = !load && ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0) begin
            case ($urandom_range(0, 3))
               0:       max_val = 4'd0;
               1:       max_val = 4'd15;
               default: max_val = 4'($urandom);
            endcase
         end
         tick();
      end

      idle();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
